// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and counter sizing.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int count_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// One-bit full adder used as the serial datapath slice.
module serial_adder_fa (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial W-bit adder: one full-adder slice fed LSB-first, one bit per clock.
// Optional SERIAL_ADDER_OVF_EN adds a two's-complement overflow output.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | waiting for start; previous result held
// ST_RUN  | one operand bit pair added per clock (W clocks)
// ST_DONE | one-cycle result-valid pulse
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic         ovf,
`endif
  output logic         c_out
);

  localparam int CW = count_width(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t         state, state_nxt;
  logic [W-1:0]   a_sr, b_sr;
  logic           carry;
  logic [CW-1:0]  count;
  logic           fa_s, fa_co;

  serial_adder_fa u_fa (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .c_in  (carry),
    .s     (fa_s),
    .c_out (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (count == LAST) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Sum fills from the MSB end so the first (LSB) result bit lands at bit 0 after W shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      count <= '0;
      sum   <= '0;
      c_out <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= c_in;
            count <= '0;
          end
        end
        ST_RUN: begin
          carry <= fa_co;
          sum   <= {fa_s, sum[W-1:1]};
          a_sr  <= {1'b0, a_sr[W-1:1]};
          b_sr  <= {1'b0, b_sr[W-1:1]};
          if (count == LAST) begin
            c_out <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= fa_co ^ carry;
`endif
          end else begin
            count <= count + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (W=8 main instance, W=2 exhaustive instance).
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic       c_in;
  logic       busy, done, c_out;
  logic [7:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf;
`endif

  logic       start2;
  logic [1:0] a2, b2;
  logic       c_in2;
  logic       busy2, done2, c_out2;
  logic [1:0] sum2;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf2;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_adder #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c_in(c_in),
    .busy(busy), .done(done), .sum(sum),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf),
`endif
    .c_out(c_out)
  );

  serial_adder #(.W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .c_in(c_in2),
    .busy(busy2), .done(done2), .sum(sum2),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf2),
`endif
    .c_out(c_out2)
  );

  // Stimulus only: issues one add and reports what it observed.
  task automatic run_add(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                         output int lat, output int nbusy,
                         output logic [7:0] s, output logic co);
    @(negedge clk);
    a = ta; b = tb_v; c_in = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); c_in = 1'($urandom);
    lat = -1; nbusy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin lat = i; break; end
    end
    s = sum; co = c_out;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; c_in2 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, sum, c_out} !== 11'd0) begin
      n_err++; $display("FAIL reset_outputs: got busy=%b done=%b sum=%h c_out=%b, want all 0", busy, done, sum, c_out);
    end
`ifdef SERIAL_ADDER_OVF_EN
    n_cmp++;
    if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
  endtask

  task automatic test_basic();
    int lat, nb; logic [7:0] s; logic co;
    run_add(8'h3C, 8'h0F, 1'b0, lat, nb, s, co);
    n_cmp++;
    if (lat !== 8) begin n_err++; $display("FAIL basic_latency: got %0d want 8", lat); end
    n_cmp++;
    if (nb !== 8) begin n_err++; $display("FAIL basic_busy_cycles: got %0d want 8", nb); end
    n_cmp++;
    if ({co, s} !== 9'h04B) begin n_err++; $display("FAIL basic_sum: got c_out=%b sum=%h want 0/4b", co, s); end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || sum !== 8'h4B) begin
      n_err++; $display("FAIL basic_hold: got done=%b sum=%h want 0/4b", done, sum);
    end
  endtask

  task automatic test_carry();
    int lat, nb; logic [7:0] s; logic co;
    run_add(8'hFF, 8'h01, 1'b0, lat, nb, s, co);
    n_cmp++;
    if ({co, s} !== 9'h100 || lat !== 8) begin
      n_err++; $display("FAIL carry_ff_01: got c_out=%b sum=%h lat=%0d want 1/00/8", co, s, lat);
    end
    run_add(8'hFF, 8'hFF, 1'b1, lat, nb, s, co);
    n_cmp++;
    if ({co, s} !== 9'h1FF || lat !== 8) begin
      n_err++; $display("FAIL carry_ff_ff_1: got c_out=%b sum=%h lat=%0d want 1/ff/8", co, s, lat);
    end
  endtask

  task automatic test_back_to_back();
    int idx[$];
    @(negedge clk);
    start = 1'b1; a = 8'h01; b = 8'h01; c_in = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (done) begin
        idx.push_back(i);
        n_cmp++;
        if ({c_out, sum} !== 9'h002) begin
          n_err++; $display("FAIL b2b_sum: got c_out=%b sum=%h want 0/02", c_out, sum);
        end
      end
      if (busy) begin a = 8'($urandom); b = 8'($urandom); c_in = 1'($urandom); end
      else begin a = 8'h01; b = 8'h01; c_in = 1'b0; end
    end
    start = 1'b0;
    n_cmp++;
    if (idx.size() !== 4) begin
      n_err++; $display("FAIL b2b_count: got %0d dones want 4", idx.size());
    end else begin
      n_cmp++;
      if (idx[0] !== 8 || idx[1] - idx[0] !== 10 || idx[2] - idx[1] !== 10 || idx[3] - idx[2] !== 10) begin
        n_err++; $display("FAIL b2b_spacing: got %0d %0d %0d %0d want 8 18 28 38", idx[0], idx[1], idx[2], idx[3]);
      end
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int nd; int lat, nb; logic [7:0] s; logic co;
    @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'hFF; c_in = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL abort_busy_before: got %b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, sum, c_out} !== 11'd0) begin
      n_err++; $display("FAIL abort_async_clear: got busy=%b done=%b sum=%h c_out=%b want all 0", busy, done, sum, c_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    n_cmp++;
    if (nd !== 0) begin n_err++; $display("FAIL abort_no_done: got %0d dones want 0", nd); end
    run_add(8'h10, 8'h20, 1'b0, lat, nb, s, co);
    n_cmp++;
    if ({co, s} !== 9'h030 || lat !== 8) begin
      n_err++; $display("FAIL abort_next_add: got c_out=%b sum=%h lat=%0d want 0/30/8", co, s, lat);
    end
  endtask

`ifdef SERIAL_ADDER_OVF_EN
  task automatic test_ovf();
    int lat, nb; logic [7:0] s; logic co;
    run_add(8'h7F, 8'h01, 1'b0, lat, nb, s, co);
    n_cmp++;
    if (s !== 8'h80 || ovf !== 1'b1) begin
      n_err++; $display("FAIL ovf_7f_01: got sum=%h ovf=%b want 80/1", s, ovf);
    end
    run_add(8'hFF, 8'h01, 1'b0, lat, nb, s, co);
    n_cmp++;
    if (s !== 8'h00 || co !== 1'b1 || ovf !== 1'b0) begin
      n_err++; $display("FAIL ovf_ff_01: got sum=%h c_out=%b ovf=%b want 00/1/0", s, co, ovf);
    end
  endtask
`endif

  task automatic test_w2_exhaustive();
    int lat; logic [2:0] exp_v;
    for (int ia = 0; ia < 4; ia++)
      for (int ib = 0; ib < 4; ib++)
        for (int ic = 0; ic < 2; ic++) begin
          @(negedge clk);
          a2 = 2'(ia); b2 = 2'(ib); c_in2 = 1'(ic); start2 = 1'b1;
          @(posedge clk); #1;
          start2 = 1'b0; a2 = 2'($urandom); b2 = 2'($urandom);
          lat = -1;
          for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done2) begin lat = i; break; end
          end
          exp_v = 3'(ia + ib + ic);
          n_cmp++;
          if ({c_out2, sum2} !== exp_v || lat !== 2) begin
            n_err++;
            $display("FAIL w2_add a=%0d b=%0d c=%0d: got {c_out,sum}=%0d lat=%0d want %0d/2",
                     ia, ib, ic, {c_out2, sum2}, lat, exp_v);
          end
        end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_reset_mid_run();
`ifdef SERIAL_ADDER_OVF_EN
    test_ovf();
`endif
    test_w2_exhaustive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
